// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg
// Shared definitions for the parametrised reorder buffer.
//   rob_type_e  : instruction class carried by every ROB entry
//   rob_state_e : retire FSM state encoding
// -----------------------------------------------------------------------------
package rob_pkg;

    typedef enum logic [1:0] {
        ROB_REG    = 2'b00,
        ROB_STORE  = 2'b01,
        ROB_BRANCH = 2'b10,
        ROB_HALT   = 2'b11
    } rob_type_e;

    typedef enum logic {
        RS_IDLE    = 1'b0,
        RS_ST_WAIT = 1'b1
    } rob_state_e;

endpackage : rob_pkg

// File: rtl/rob_param.sv
// -----------------------------------------------------------------------------
// rob_param
// Parametrised reorder buffer. The decoder allocates entries in program order
// at the tail. The ALU and LSB write results back by entry id. Entries retire
// in order from the head to the register file, the LSB (store release) and
// the branch predictor.
//
// Ports
//   clk, rst, rdy, flush          clock, sync reset, global enable, flush
//   alloc_*                       allocation request from the decoder
//   alloc_id, full, count         allocation status
//   q1_*/q2_*                     operand queries (combinational, bypassed)
//   alu_*, lsb_*                  writeback ports
//   store_done                    LSB finished the released store
//   cm_reg_*                      register-file commit pulse
//   cm_store_*                    store-release pulse
//   bp_*                          predictor update pulse
//   rollback_*                    mispredict redirect pulse
//   halt                          sticky, set when a halt entry retires
//
// Handshake: alloc_valid is accepted on an edge only when rdy=1, full=0 and
// no mispredict flush happens on that edge; otherwise the decoder must hold
// the request. All *_valid outputs are single-cycle registered pulses.
// -----------------------------------------------------------------------------
module rob_param
    import rob_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int IDW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [1:0]       alloc_type,
    input  logic [4:0]       alloc_rd,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             alloc_pred,
    input  logic             alloc_ready,
    input  logic [XLEN-1:0]  alloc_value,
    output logic [IDW-1:0]   alloc_id,
    output logic             full,
    output logic [IDW:0]     count,
    input  logic [IDW-1:0]   q1_id,
    input  logic [IDW-1:0]   q2_id,
    output logic [XLEN-1:0]  q1_value,
    output logic [XLEN-1:0]  q2_value,
    output logic             q1_ready,
    output logic             q2_ready,
    input  logic             alu_valid,
    input  logic [IDW-1:0]   alu_id,
    input  logic [XLEN-1:0]  alu_value,
    input  logic             alu_taken,
    input  logic [XLEN-1:0]  alu_target,
    input  logic             lsb_valid,
    input  logic [IDW-1:0]   lsb_id,
    input  logic [XLEN-1:0]  lsb_value,
    input  logic             store_done,
    output logic             cm_reg_valid,
    output logic [4:0]       cm_reg_rd,
    output logic [XLEN-1:0]  cm_reg_value,
    output logic [IDW-1:0]   cm_reg_id,
    output logic             cm_store_valid,
    output logic [IDW-1:0]   cm_store_id,
    output logic             bp_valid,
    output logic [XLEN-1:0]  bp_pc,
    output logic             bp_taken,
    output logic             rollback_valid,
    output logic [XLEN-1:0]  rollback_pc,
    output logic             halt
);

    localparam int CW = IDW + 1;

    // Entry storage, one array per field
    rob_type_e        type_q  [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic             pred_q  [DEPTH];
    logic             taken_q [DEPTH];
    logic             ready_q [DEPTH];
    logic [XLEN-1:0]  value_q [DEPTH];

    logic [IDW-1:0]   head_q, tail_q;
    logic [CW-1:0]    count_q;
    rob_state_e       state_q, state_d;
    logic             halt_q;

    logic             cm_reg_valid_q, cm_store_valid_q, bp_valid_q, rollback_valid_q;
    logic [4:0]       cm_reg_rd_q;
    logic [XLEN-1:0]  cm_reg_value_q, bp_pc_q, rollback_pc_q;
    logic [IDW-1:0]   cm_reg_id_q, cm_store_id_q;
    logic             bp_taken_q;

    // Retire decision signals
    logic             head_ready;
    rob_type_e        head_type;
    logic             retire_go, pop;
    logic             fire_reg, fire_store, fire_bp, fire_halt, mispredict;
    logic             alloc_fire;
    logic             clear;

    assign clear      = rst | flush;
    assign full       = (count_q == CW'(DEPTH));
    assign alloc_id   = tail_q;
    assign count      = count_q;
    assign halt       = halt_q;
    assign head_ready = (count_q != '0) && ready_q[head_q];
    assign head_type  = type_q[head_q];

    // ---------------- retire FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= RS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- retire FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            RS_IDLE: begin
                if (rdy && !halt_q && head_ready && head_type == ROB_STORE) begin
                    state_d = RS_ST_WAIT;
                end
            end
            RS_ST_WAIT: begin
                if (rdy && store_done) begin
                    state_d = RS_IDLE;
                end
            end
            default: state_d = RS_IDLE;
        endcase
    end

    // ---------------- retire FSM: outputs ----------------
    always_comb begin
        retire_go  = rdy && !halt_q && (state_q == RS_IDLE) && head_ready;
        fire_reg   = retire_go && (head_type == ROB_REG);
        fire_store = retire_go && (head_type == ROB_STORE);
        fire_bp    = retire_go && (head_type == ROB_BRANCH);
        fire_halt  = retire_go && (head_type == ROB_HALT);
        mispredict = fire_bp && (taken_q[head_q] != pred_q[head_q]);
        // A store leaves the buffer only once the LSB reports it performed
        pop        = fire_reg || fire_bp || fire_halt
                     || (rdy && (state_q == RS_ST_WAIT) && store_done);
        // A mispredict wipes the buffer, so a same-cycle allocation is lost
        alloc_fire = rdy && alloc_valid && !full && !mispredict;
    end

    // ---------------- entries, pointers, registered pulses ----------------
    always_ff @(posedge clk) begin
        if (clear) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            halt_q           <= 1'b0;
            cm_reg_valid_q   <= 1'b0;
            cm_store_valid_q <= 1'b0;
            bp_valid_q       <= 1'b0;
            rollback_valid_q <= 1'b0;
            cm_reg_rd_q      <= '0;
            cm_reg_value_q   <= '0;
            cm_reg_id_q      <= '0;
            cm_store_id_q    <= '0;
            bp_pc_q          <= '0;
            bp_taken_q       <= 1'b0;
            rollback_pc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ready_q[i] <= 1'b0;
            end
        end else begin
            cm_reg_valid_q   <= 1'b0;
            cm_store_valid_q <= 1'b0;
            bp_valid_q       <= 1'b0;
            rollback_valid_q <= 1'b0;
            if (rdy) begin
                if (mispredict) begin
                    head_q  <= '0;
                    tail_q  <= '0;
                    count_q <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        ready_q[i] <= 1'b0;
                    end
                end else begin
                    if (alloc_fire) begin
                        type_q[tail_q]  <= rob_type_e'(alloc_type);
                        rd_q[tail_q]    <= alloc_rd;
                        pc_q[tail_q]    <= alloc_pc;
                        pred_q[tail_q]  <= alloc_pred;
                        // A pre-resolved entry is treated as correctly predicted
                        taken_q[tail_q] <= alloc_pred;
                        ready_q[tail_q] <= alloc_ready;
                        value_q[tail_q] <= alloc_value;
                    end
                    if (alu_valid) begin
                        ready_q[alu_id] <= 1'b1;
                        if (type_q[alu_id] == ROB_BRANCH) begin
                            value_q[alu_id] <= alu_target;
                            taken_q[alu_id] <= alu_taken;
                        end else begin
                            value_q[alu_id] <= alu_value;
                        end
                    end
                    if (lsb_valid) begin
                        ready_q[lsb_id] <= 1'b1;
                        value_q[lsb_id] <= lsb_value;
                    end
                    head_q  <= head_q + IDW'(pop);
                    tail_q  <= tail_q + IDW'(alloc_fire);
                    count_q <= count_q + CW'(alloc_fire) - CW'(pop);
                end

                if (fire_reg) begin
                    cm_reg_valid_q <= 1'b1;
                    cm_reg_rd_q    <= rd_q[head_q];
                    cm_reg_value_q <= value_q[head_q];
                    cm_reg_id_q    <= head_q;
                end
                if (fire_store) begin
                    cm_store_valid_q <= 1'b1;
                    cm_store_id_q    <= head_q;
                end
                if (fire_bp) begin
                    bp_valid_q <= 1'b1;
                    bp_pc_q    <= pc_q[head_q];
                    bp_taken_q <= taken_q[head_q];
                end
                if (mispredict) begin
                    rollback_valid_q <= 1'b1;
                    rollback_pc_q    <= value_q[head_q];
                end
                if (fire_halt) begin
                    halt_q <= 1'b1;
                end
            end
        end
    end

    assign cm_reg_valid   = cm_reg_valid_q;
    assign cm_reg_rd      = cm_reg_rd_q;
    assign cm_reg_value   = cm_reg_value_q;
    assign cm_reg_id      = cm_reg_id_q;
    assign cm_store_valid = cm_store_valid_q;
    assign cm_store_id    = cm_store_id_q;
    assign bp_valid       = bp_valid_q;
    assign bp_pc          = bp_pc_q;
    assign bp_taken       = bp_taken_q;
    assign rollback_valid = rollback_valid_q;
    assign rollback_pc    = rollback_pc_q;

    // ---------------- operand queries with writeback bypass ----------------
    // LSB wins an id clash with the ALU (an illegal case, but deterministic).
    always_comb begin
        q1_value = value_q[q1_id];
        q1_ready = ready_q[q1_id];
        if (alu_valid && alu_id == q1_id) begin
            q1_ready = 1'b1;
            q1_value = (type_q[q1_id] == ROB_BRANCH) ? alu_target : alu_value;
        end
        if (lsb_valid && lsb_id == q1_id) begin
            q1_ready = 1'b1;
            q1_value = lsb_value;
        end
    end

    always_comb begin
        q2_value = value_q[q2_id];
        q2_ready = ready_q[q2_id];
        if (alu_valid && alu_id == q2_id) begin
            q2_ready = 1'b1;
            q2_value = (type_q[q2_id] == ROB_BRANCH) ? alu_target : alu_value;
        end
        if (lsb_valid && lsb_id == q2_id) begin
            q2_ready = 1'b1;
            q2_value = lsb_value;
        end
    end

endmodule : rob_param

// File: tb/tb_rob_param.sv
module tb_rob_param;

  localparam int DEPTH = 16;
  localparam int XLEN  = 32;
  localparam int IDW   = 4;

  localparam logic [1:0] T_REG    = 2'b00;
  localparam logic [1:0] T_STORE  = 2'b01;
  localparam logic [1:0] T_BRANCH = 2'b10;
  localparam logic [1:0] T_HALT   = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, rdy, flush;
  logic            alloc_valid, alloc_pred, alloc_ready;
  logic [1:0]      alloc_type;
  logic [4:0]      alloc_rd;
  logic [XLEN-1:0] alloc_pc, alloc_value;
  logic [IDW-1:0]  alloc_id;
  logic            full;
  logic [IDW:0]    count;
  logic [IDW-1:0]  q1_id, q2_id;
  logic [XLEN-1:0] q1_value, q2_value;
  logic            q1_ready, q2_ready;
  logic            alu_valid, alu_taken;
  logic [IDW-1:0]  alu_id;
  logic [XLEN-1:0] alu_value, alu_target;
  logic            lsb_valid;
  logic [IDW-1:0]  lsb_id;
  logic [XLEN-1:0] lsb_value;
  logic            store_done;
  logic            cm_reg_valid;
  logic [4:0]      cm_reg_rd;
  logic [XLEN-1:0] cm_reg_value;
  logic [IDW-1:0]  cm_reg_id;
  logic            cm_store_valid;
  logic [IDW-1:0]  cm_store_id;
  logic            bp_valid, bp_taken;
  logic [XLEN-1:0] bp_pc;
  logic            rollback_valid;
  logic [XLEN-1:0] rollback_pc;
  logic            halt;

  rob_param #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_type(alloc_type), .alloc_rd(alloc_rd),
    .alloc_pc(alloc_pc), .alloc_pred(alloc_pred), .alloc_ready(alloc_ready),
    .alloc_value(alloc_value), .alloc_id(alloc_id), .full(full), .count(count),
    .q1_id(q1_id), .q2_id(q2_id), .q1_value(q1_value), .q2_value(q2_value),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .alu_valid(alu_valid), .alu_id(alu_id), .alu_value(alu_value),
    .alu_taken(alu_taken), .alu_target(alu_target),
    .lsb_valid(lsb_valid), .lsb_id(lsb_id), .lsb_value(lsb_value),
    .store_done(store_done),
    .cm_reg_valid(cm_reg_valid), .cm_reg_rd(cm_reg_rd), .cm_reg_value(cm_reg_value),
    .cm_reg_id(cm_reg_id), .cm_store_valid(cm_store_valid), .cm_store_id(cm_store_id),
    .bp_valid(bp_valid), .bp_pc(bp_pc), .bp_taken(bp_taken),
    .rollback_valid(rollback_valid), .rollback_pc(rollback_pc), .halt(halt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_reg_q[$];    // {cm_reg_id, rd, value}
  logic [63:0] exp_store_q[$];  // store id
  logic [63:0] exp_bp_q[$];     // {pc, taken}
  logic [63:0] exp_rb_q[$];     // rollback pc

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cm_reg_valid) begin
      check_eq("reg_pending", 64'(exp_reg_q.size() > 0), 64'd1);
      if (exp_reg_q.size() > 0)
        check_eq("reg_commit", {23'b0, cm_reg_id, cm_reg_rd, cm_reg_value}, exp_reg_q.pop_front());
    end
    if (cm_store_valid) begin
      check_eq("store_pending", 64'(exp_store_q.size() > 0), 64'd1);
      if (exp_store_q.size() > 0)
        check_eq("store_release", 64'(cm_store_id), exp_store_q.pop_front());
    end
    if (bp_valid) begin
      check_eq("bp_pending", 64'(exp_bp_q.size() > 0), 64'd1);
      if (exp_bp_q.size() > 0)
        check_eq("bp_update", {31'b0, bp_pc, bp_taken}, exp_bp_q.pop_front());
    end
    if (rollback_valid) begin
      check_eq("rb_pending", 64'(exp_rb_q.size() > 0), 64'd1);
      if (exp_rb_q.size() > 0)
        check_eq("rollback", 64'(rollback_pc), exp_rb_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_type = T_REG; alloc_rd = 0; alloc_pc = 0;
    alloc_pred = 0; alloc_ready = 0; alloc_value = 0;
    alu_valid = 0; alu_id = 0; alu_value = 0; alu_taken = 0; alu_target = 0;
    lsb_valid = 0; lsb_id = 0; lsb_value = 0; store_done = 0;
    q1_id = 0; q2_id = 0;
  endtask

  task automatic do_alloc(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                          input logic pred, input logic rdyb, input logic [31:0] val,
                          output logic [IDW-1:0] id);
    id = alloc_id;
    alloc_valid = 1; alloc_type = t; alloc_rd = rd; alloc_pc = pc;
    alloc_pred = pred; alloc_ready = rdyb; alloc_value = val;
    tick();
    alloc_valid = 0;
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 64 && count != 0; n++) tick();
    check_eq(tag, 64'(count), 64'd0);
  endtask

  task automatic wait_store(input string tag);
    logic seen = 0;
    for (int n = 0; n < 16 && !seen; n++) begin
      tick();
      seen = cm_store_valid;
    end
    check_eq(tag, 64'(seen), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0]    vals[DEPTH];
  logic [IDW-1:0] id, sid, rid, bid, id2, a_id;
  logic [31:0]    v1, v4;

  initial begin
    idle_inputs();
    rst = 1; rdy = 1; flush = 0;
    tick(); tick();
    rst = 0;
    check_eq("rst_count", 64'(count), 0);
    check_eq("rst_full", 64'(full), 0);
    check_eq("rst_alloc_id", 64'(alloc_id), 0);
    check_eq("rst_halt", 64'(halt), 0);
    check_eq("rst_rollback_pc", 64'(rollback_pc), 0);
    check_eq("rst_pulses", {cm_reg_valid, cm_store_valid, bp_valid, rollback_valid}, 0);

    // Fill with unresolved reg-writes
    for (int i = 0; i < DEPTH; i++) begin
      vals[i] = $urandom;
      do_alloc(T_REG, 5'(i + 1), 32'(i * 4), 0, 0, 0, id);
    end
    check_eq("fill_full", 64'(full), 1);
    check_eq("fill_count", 64'(count), DEPTH);
    check_eq("fill_alloc_id", 64'(alloc_id), 0);
    do_alloc(T_REG, 5'd31, 0, 0, 1, 0, id);
    check_eq("over_count", 64'(count), DEPTH);
    check_eq("over_alloc_id", 64'(alloc_id), 0);

    // Resolve in reverse order, both writeback ports at once
    for (int i = 0; i < DEPTH; i++)
      exp_reg_q.push_back({23'b0, 4'(i), 5'(i + 1), vals[i]});
    for (int j = DEPTH - 1; j > 0; j -= 2) begin
      alu_valid = 1; alu_id = IDW'(j);     alu_value = vals[j];
      lsb_valid = 1; lsb_id = IDW'(j - 1); lsb_value = vals[j - 1];
      tick();
    end
    alu_valid = 0; lsb_valid = 0;
    // Head retires from a full buffer: same-cycle alloc must be refused
    alloc_valid = 1; alloc_type = T_REG; alloc_ready = 1;
    tick();
    alloc_valid = 0;
    check_eq("full_retire_count", 64'(count), DEPTH - 1);
    check_eq("full_retire_alloc_id", 64'(alloc_id), 0);
    wait_drain("fill_drain");

    // Directed register commit
    do_alloc(T_REG, 5'd5, 32'h40, 0, 0, 0, id);
    exp_reg_q.push_back({23'b0, id, 5'd5, 32'h1234});
    alu_valid = 1; alu_id = id; alu_value = 32'h1234;
    tick();
    alu_valid = 0;
    wait_drain("reg_drain");

    // Bypass on operand queries
    for (int i = 0; i < 4; i++) do_alloc(T_REG, 5'(10 + i), 0, 0, 0, 0, id);
    q1_id = 3; q2_id = 2;
    #1;
    check_eq("q1_unready", 64'(q1_ready), 0);
    alu_valid = 1; alu_id = 3; alu_value = 7;
    lsb_valid = 1; lsb_id = 2; lsb_value = 9;
    #1;
    check_eq("q1_bypass", {q1_ready, q1_value}, {1'b1, 32'd7});
    check_eq("q2_bypass", {q2_ready, q2_value}, {1'b1, 32'd9});
    tick();
    alu_valid = 0; lsb_valid = 0;
    #1;
    check_eq("q1_stored", {q1_ready, q1_value}, {1'b1, 32'd7});
    // lsb wins a clash on the same id (inputs removed before the next edge)
    q1_id = 4; alu_valid = 1; alu_id = 4; alu_value = 32'h11;
    lsb_valid = 1; lsb_id = 4; lsb_value = 32'h22;
    #1;
    check_eq("q1_clash", {q1_ready, q1_value}, {1'b1, 32'h22});
    alu_valid = 0; lsb_valid = 0;
    v1 = $urandom; v4 = $urandom;
    exp_reg_q.push_back({23'b0, 4'd1, 5'd10, v1});
    exp_reg_q.push_back({23'b0, 4'd2, 5'd11, 32'd9});
    exp_reg_q.push_back({23'b0, 4'd3, 5'd12, 32'd7});
    exp_reg_q.push_back({23'b0, 4'd4, 5'd13, v4});
    tick();
    alu_valid = 1; alu_id = 4; alu_value = v4;
    lsb_valid = 1; lsb_id = 1; lsb_value = v1;
    tick();
    alu_valid = 0; lsb_valid = 0;
    wait_drain("bypass_drain");

    // Store two-phase commit followed by a reg entry
    do_alloc(T_STORE, 0, 32'h80, 0, 0, 0, sid);
    do_alloc(T_REG, 5'd7, 32'h84, 0, 1, 32'h55, rid);
    exp_store_q.push_back(64'(sid));
    exp_reg_q.push_back({23'b0, rid, 5'd7, 32'h55});
    lsb_valid = 1; lsb_id = sid; lsb_value = 32'hdead;
    tick();
    lsb_valid = 0;
    wait_store("store_seen");
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("store_pulse_once", 64'(cm_store_valid), 0);
      check_eq("store_wait_count", 64'(count), 2);
      check_eq("store_wait_noreg", 64'(cm_reg_valid), 0);
    end
    store_done = 1;
    tick();
    store_done = 0;
    check_eq("store_retired", 64'(count), 1);
    tick();
    check_eq("after_store_reg", 64'(cm_reg_valid), 1);
    check_eq("after_store_count", 64'(count), 0);

    // Correctly predicted branch
    do_alloc(T_BRANCH, 0, 32'h300, 1, 0, 0, bid);
    exp_bp_q.push_back({31'b0, 32'h300, 1'b1});
    alu_valid = 1; alu_id = bid; alu_taken = 1; alu_target = 32'h340;
    tick();
    alu_valid = 0;
    wait_drain("bp_ok_drain");

    // Mispredicted branch with 3 younger entries and a same-cycle alloc
    do_alloc(T_BRANCH, 0, 32'h100, 0, 0, 0, bid);
    for (int i = 0; i < 3; i++) do_alloc(T_REG, 5'(20 + i), 0, 0, 0, 0, id);
    exp_bp_q.push_back({31'b0, 32'h100, 1'b1});
    exp_rb_q.push_back(64'h200);
    alu_valid = 1; alu_id = bid; alu_taken = 1; alu_target = 32'h200;
    tick();
    alu_valid = 0;
    alloc_valid = 1; alloc_type = T_REG; alloc_rd = 9; alloc_ready = 1;
    tick();
    alloc_valid = 0;
    check_eq("mp_rollback", 64'(rollback_valid), 1);
    check_eq("mp_rollback_pc", 64'(rollback_pc), 64'h200);
    check_eq("mp_bp_taken", 64'(bp_taken), 1);
    check_eq("mp_count", 64'(count), 0);
    check_eq("mp_alloc_id", 64'(alloc_id), 0);
    tick();
    check_eq("mp_pulse_once", 64'(rollback_valid), 0);

    // Halt blocks further retire
    do_alloc(T_HALT, 0, 32'h500, 0, 1, 0, id);
    do_alloc(T_REG, 5'd3, 32'h504, 0, 1, 32'h77, id);
    for (int k = 0; k < 5; k++) tick();
    check_eq("halt_set", 64'(halt), 1);
    check_eq("halt_count", 64'(count), 1);

    // Reset in the middle of a store wait
    rst = 1; tick(); rst = 0;
    check_eq("rst2_halt", 64'(halt), 0);
    do_alloc(T_STORE, 0, 32'h600, 0, 1, 0, sid);
    exp_store_q.push_back(64'(sid));
    wait_store("store2_seen");
    rst = 1; tick(); rst = 0;
    check_eq("rst_stwait_count", 64'(count), 0);
    store_done = 1; tick(); store_done = 0;
    check_eq("late_store_done", 64'(count), 0);
    do_alloc(T_REG, 5'd11, 0, 0, 1, 32'habc, id);
    exp_reg_q.push_back({23'b0, id, 5'd11, 32'habc});
    wait_drain("post_rst_drain");

    // rdy low freezes everything
    do_alloc(T_REG, 5'd1, 0, 0, 0, 0, id);
    do_alloc(T_REG, 5'd2, 0, 0, 0, 0, id2);
    a_id = alloc_id;
    rdy = 0;
    alloc_valid = 1; alloc_type = T_REG; alloc_ready = 1;
    alu_valid = 1; alu_id = id; alu_value = 32'h99;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("frz_count", 64'(count), 2);
      check_eq("frz_alloc_id", 64'(alloc_id), 64'(a_id));
      check_eq("frz_noreg", 64'(cm_reg_valid), 0);
    end
    idle_inputs();
    rdy = 1;
    tick(); tick();
    check_eq("frz_wb_dropped", 64'(count), 2);
    flush = 1; tick(); flush = 0;
    check_eq("flush_count", 64'(count), 0);
    check_eq("flush_alloc_id", 64'(alloc_id), 0);

    // Reset then rdy low: outputs stay at reset values
    do_alloc(T_REG, 5'd4, 0, 0, 0, 0, id);
    rst = 1; rdy = 0; tick(); rst = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("rst_rdy0_count", 64'(count), 0);
      check_eq("rst_rdy0_outs", {full, halt, cm_reg_valid, cm_store_valid, bp_valid, rollback_valid}, 0);
    end
    rdy = 1;
    tick();

    check_eq("reg_q_empty", 64'(exp_reg_q.size()), 0);
    check_eq("store_q_empty", 64'(exp_store_q.size()), 0);
    check_eq("bp_q_empty", 64'(exp_bp_q.size()), 0);
    check_eq("rb_q_empty", 64'(exp_rb_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the out-of-order RISC-V core; successor to the fixed 16-entry ROB. It sits between the decoder, which allocates entries in program order, and the ALU/LSB result buses, register file, LSB and branch predictor, to which it retires in order. New over the previous generation:
- DEPTH/XLEN parameters and an occupancy counter.
- A two-phase store-commit handshake with the LSB.
- Same-cycle writeback bypass on operand queries.
- A halt-commit type.

## Interface
- DEPTH, 16: entries; power of two, ≥4.
- XLEN, 32: data/PC width.
- IDW, $clog2(DEPTH): entry-id width.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  external flush; same effect as rst on the next edge
- alloc_valid  in  1  decoder pushes an instruction this cycle
- alloc_type  in  2  00 reg-write, 01 store, 10 branch, 11 halt
- alloc_rd  in  5  destination register
- alloc_pc  in  XLEN  instruction PC
- alloc_pred  in  1  predicted taken
- alloc_ready  in  1  result already known
- alloc_value  in  XLEN  known result
- alloc_id  out  IDW  id the next allocation receives (combinational: tail)
- full  out  1  count==DEPTH (combinational)
- count  out  IDW+1  occupancy
- q1_id, q2_id  in  IDW  operand query ids
- q1_value, q2_value  out  XLEN  combinational, with bypass
- q1_ready, q2_ready  out  1  combinational, with bypass
- alu_valid  in  1  ALU writeback
- alu_id  in  IDW  ALU target entry
- alu_value  in  XLEN  ALU result
- alu_taken  in  1  branch outcome
- alu_target  in  XLEN  branch target
- lsb_valid  in  1  LSB writeback
- lsb_id  in  IDW  LSB target entry
- lsb_value  in  XLEN  LSB result
- store_done  in  1  LSB has performed the committed store
- cm_reg_valid  out  1  register-file commit pulse
- cm_reg_rd  out  5  committed rd
- cm_reg_value  out  XLEN  committed value
- cm_reg_id  out  IDW  committed entry id
- cm_store_valid  out  1  store-release pulse to LSB
- cm_store_id  out  IDW  released store entry id
- bp_valid  out  1  predictor update pulse
- bp_pc  out  XLEN  branch PC
- bp_taken  out  1  resolved outcome
- rollback_valid  out  1  mispredict pulse
- rollback_pc  out  XLEN  redirect PC
- halt  out  1  sticky; set when a halt entry commits

## Operation
- Circular buffer with head (oldest), tail (next free) and count, each IDW/IDW+1 bits. Pointers wrap modulo DEPTH.
- Allocate when alloc_valid && !full: write the tail entry, tail+1, count+1. alloc_valid while full is ignored; the decoder must hold.
- Writeback: alu_valid sets ready and value at alu_id. For a branch entry, value←alu_target and taken←alu_taken. lsb_valid sets ready and value at lsb_id. Both ports may fire in one cycle on different ids.
- Retire FSM, states IDLE and ST_WAIT. In IDLE, with count>0 and entry[head].ready:
  - Type 00: pulse cm_reg.
  - Type 10: pulse bp. If taken≠pred, also pulse rollback_valid with rollback_pc=value, and flush all entries on the same edge.
  - Type 11: set halt, no further retire.
  - In each of the above, head+1 and count−1.
  - Type 01: pulse cm_store and move to ST_WAIT.
- In ST_WAIT: no retire until store_done. Then head+1, count−1, return to IDLE.
- Query: value/ready of the queried entry. If alu_valid or lsb_valid targets the queried id this cycle, return that value with ready=1; lsb takes priority on an id clash (illegal).
- Alloc and retire in the same cycle: count unchanged. A retire that frees a full buffer does not accept the same-cycle alloc; full is combinational from the registered count.

## Timing
- All commit/bp/rollback outputs are registered one-cycle pulses, driven the edge after the retire decision. Default 0 every cycle.
- Reset/flush: head=tail=0, count=0, FSM IDLE, all ready bits 0, all pulses 0, rollback_pc=0, halt=0.
- Flush/rst has priority over alloc, writeback and retire in the same cycle.
- Mispredict flush also drops any same-cycle allocation.
- rst mid ST_WAIT returns to IDLE; a later store_done is ignored.
- Minimum latency from ready-at-head to cm_* pulse: 1 cycle. Throughput: one retire per cycle; stores take ≥2 cycles.

## Structure
- Shared package `rob_pkg`: type encodings ROB_REG/ROB_STORE/ROB_BRANCH/ROB_HALT, FSM state encoding.
- No sub-module. Entry storage is per-field arrays.

## Test plan
- Fill: 16 allocs with no retire -> full=1 and count=16 after the 16th; a 17th alloc is ignored; alloc_id=0 wrapped.
- Reg commit: alloc type 00 rd=5, then alu_valid value=0x1234 -> next cycle cm_reg_valid=1, rd=5, value=0x1234, count back to 0.
- Store: store entry ready -> cm_store pulse 1 cycle, no retire for 3 cycles until store_done -> retire; the following reg entry commits the next cycle.
- Mispredict: branch pred=0, alu_taken=1, target=0x200 with 3 younger entries -> rollback_valid=1, rollback_pc=0x200, bp_taken=1, count=0, alloc_id=0.
- Bypass: q1_id=3 while alu_valid id=3 value=7 -> q1_ready=1, q1_value=7 in the same cycle.
- Reset mid-ST_WAIT, and rdy=0 for 5 cycles -> all outputs at reset values; state frozen while rdy=0.
